mem_stage: RTL and testbench

Memory-access stage of the in-order RV32I pipeline, directly downstream of the execute stage. It consumes the execute stage's registered pc, instruction, ALU result and store value; loads and stores go to a single-ported data memory through a req/ack handshake, and every other instruction passes through. It produces the writeback operand and stalls upstream while a memory access is outstanding.

---
 rtl/mem_stage.sv | 248 ++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage; loads/stores go to a single-ported data memory via req/ack.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of issuing them force-aligned.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid_in,
  input  logic [31:0]       i_pc_in,
  input  logic [31:0]       i_instr_in,
  input  logic [31:0]       i_data_in,
  input  logic [31:0]       i_store_val,
  output logic              o_stall_m,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_wdata,
  output logic [3:0]        o_dmem_be,
  input  logic              i_dmem_ack,
  input  logic [31:0]       i_dmem_rdata,
  output logic              o_valid_out,
  output logic [31:0]       o_pc_out,
  output logic [31:0]       o_instr_out,
  output logic [31:0]       o_result,
  output logic              o_misaligned
);

  // state   | meaning
  // ST_IDLE | nothing outstanding; valid_in is accepted, dmem_ack ignored
  // ST_BUSY | request held on the memory port until dmem_ack; valid_in ignored
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_is_store;
  size_t       r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_store_val;
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  logic        r_valid_out;
  logic [31:0] r_result;
  logic [31:0] r_pc_out;
  logic [31:0] r_instr_out;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  size_t       w_size;
  logic        w_unsigned;
  logic        w_busy;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  logic        w_capture;
  logic        w_valid_nxt;
  logic [31:0] w_result_nxt;
  logic [31:0] w_pc_out_nxt;
  logic [31:0] w_instr_out_nxt;
  logic        w_misal_nxt;

  assign w_opcode   = i_instr_in[6:0];
  assign w_funct3   = i_instr_in[14:12];
  assign w_is_load  = (w_opcode == OPC_LOAD);
  assign w_is_store = (w_opcode == OPC_STORE);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_unsigned = w_is_load & ((w_funct3 == 3'b100) | (w_funct3 == 3'b101));

  // Unused load/store size encodings fall back to a full word.
  always_comb begin
    w_size = SZ_W;
    if (w_is_store) begin
      case (w_funct3)
        3'b000:  w_size = SZ_B;
        3'b001:  w_size = SZ_H;
        default: w_size = SZ_W;
      endcase
    end else begin
      case (w_funct3)
        3'b000, 3'b100: w_size = SZ_B;
        3'b001, 3'b101: w_size = SZ_H;
        default:        w_size = SZ_W;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misal;
  logic r_misaligned;

  always_comb begin
    case (w_size)
      SZ_H:    w_misal = i_data_in[0];
      SZ_W:    w_misal = |i_data_in[1:0];
      default: w_misal = 1'b0;
    endcase
  end
`endif

  // Lane steering uses only the captured access, so the bus stays stable while upstream is stalled.
  always_comb begin
    case (r_size)
      SZ_B: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_store_val[7:0]}};
      end
      SZ_H: begin
        w_be    = 4'b0011 << {r_addr[1], 1'b0};
        w_wdata = {2{r_store_val[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_store_val;
      end
    endcase
  end

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = i_dmem_rdata[7:0];
      2'd1:    w_byte = i_dmem_rdata[15:8];
      2'd2:    w_byte = i_dmem_rdata[23:16];
      default: w_byte = i_dmem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (r_size)
      SZ_B:    w_load_data = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_H:    w_load_data = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_data = i_dmem_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_capture       = 1'b0;
    w_valid_nxt     = 1'b0;
    w_result_nxt    = r_result;
    w_pc_out_nxt    = r_pc_out;
    w_instr_out_nxt = r_instr_out;
    w_misal_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_valid_in) begin
          if (!w_is_mem) begin
            w_valid_nxt     = 1'b1;
            w_result_nxt    = i_data_in;
            w_pc_out_nxt    = i_pc_in;
            w_instr_out_nxt = i_instr_in;
`ifdef MEM_MISALIGN_TRAP_EN
          end else if (w_misal) begin
            w_valid_nxt     = 1'b1;
            w_misal_nxt     = 1'b1;
            w_result_nxt    = i_data_in;
            w_pc_out_nxt    = i_pc_in;
            w_instr_out_nxt = i_instr_in;
`endif
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (i_dmem_ack) begin
          w_valid_nxt     = 1'b1;
          w_result_nxt    = r_is_store ? r_addr : w_load_data;
          w_pc_out_nxt    = r_pc;
          w_instr_out_nxt = r_instr;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_is_store  <= 1'b0;
      r_size      <= SZ_B;
      r_unsigned  <= 1'b0;
      r_addr      <= 32'h0;
      r_store_val <= 32'h0;
      r_pc        <= 32'h0;
      r_instr     <= 32'h0;
      r_valid_out <= 1'b0;
      r_result    <= 32'h0;
      r_pc_out    <= 32'h0;
      r_instr_out <= 32'h0;
    end else begin
      if (w_capture) begin
        r_is_store  <= w_is_store;
        r_size      <= w_size;
        r_unsigned  <= w_unsigned;
        r_addr      <= i_data_in;
        r_store_val <= i_store_val;
        r_pc        <= i_pc_in;
        r_instr     <= i_instr_in;
      end
      r_valid_out <= w_valid_nxt;
      r_result    <= w_result_nxt;
      r_pc_out    <= w_pc_out_nxt;
      r_instr_out <= w_instr_out_nxt;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) r_misaligned <= 1'b0;
    else       r_misaligned <= w_misal_nxt;
  end
  assign o_misaligned = r_misaligned;
`else
  assign o_misaligned = w_misal_nxt;
`endif

  // Memory port is driven only while an access is outstanding.
  assign w_busy       = (r_state == ST_BUSY);
  assign o_stall_m    = w_busy;
  assign o_dmem_req   = w_busy;
  assign o_dmem_we    = w_busy & r_is_store;
  assign o_dmem_addr  = w_busy ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign o_dmem_be    = w_busy ? w_be : 4'b0000;
  assign o_dmem_wdata = (w_busy & r_is_store) ? w_wdata : 32'h0;

  assign o_valid_out  = r_valid_out;
  assign o_pc_out     = r_pc_out;
  assign o_instr_out  = r_instr_out;
  assign o_result     = r_result;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a byte-lane reference model.
`timescale 1ns/1ps
module tb_mem_stage;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] pc_in = 32'h0, instr_in = 32'h0, data_in = 32'h0, store_val = 32'h0;
  logic        stall_m, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        valid_out;
  logic [31:0] pc_out, instr_out, result;
  logic        misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid_in(valid_in), .i_pc_in(pc_in), .i_instr_in(instr_in),
    .i_data_in(data_in), .i_store_val(store_val), .o_stall_m(stall_m), .o_dmem_req(dmem_req),
    .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be),
    .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata), .o_valid_out(valid_out), .o_pc_out(pc_out),
    .o_instr_out(instr_out), .o_result(result), .o_misaligned(misaligned)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (tests=%0d)", n_tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3);
    logic [31:0] x;
    x        = $urandom;
    x[6:0]   = opc;
    x[14:12] = f3;
    return x;
  endfunction

  // Reference model: access width in bytes and lane offset inside the word.
  function automatic int unsigned m_nbytes(input bit st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : ((f3 == 3'd1) ? 2 : 4);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int unsigned m_off(input logic [31:0] a, input int unsigned n);
    return (a % 4) - (a % n);
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input int unsigned n);
    int unsigned m;
    m = ((1 << n) - 1) << m_off(a, n);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] sv, input int unsigned n);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = sv[8*(b % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input int unsigned n, input bit uns);
    logic [31:0] v, mask;
    v = rd >> (8 * m_off(a, n));
    if (n == 4) return v;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b1; instr_in = mk_instr(OPC_LOAD, 3'b010); data_in = 32'h100;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({stall_m, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, valid_out, pc_out,
         instr_out, result, misaligned} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got stall=%b req=%b we=%b addr=%h wdata=%h be=%b vout=%b pc=%h instr=%h res=%h mis=%b, want all 0",
               stall_m, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, valid_out, pc_out, instr_out, result, misaligned);
    end
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({stall_m, dmem_req, valid_out} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release: got stall=%b req=%b vout=%b, want 000", stall_m, dmem_req, valid_out);
    end
  endtask

  task automatic test_passthrough();
    @(posedge clk); #1;
    valid_in = 1'b1; instr_in = 32'h00B5_0533; data_in = 32'h1234; pc_in = 32'h40;
    @(negedge clk);
    n_tests++;
    if ({stall_m, dmem_req} !== 2'b00) begin
      n_fail++; $display("FAIL pass_accept: got stall=%b req=%b, want 0 0", stall_m, dmem_req);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; data_in = $urandom;
    @(negedge clk);
    n_tests++;
    if ({valid_out, result, pc_out, instr_out, stall_m, dmem_req} !== {1'b1, 32'h1234, 32'h40, 32'h00B5_0533, 2'b00}) begin
      n_fail++;
      $display("FAIL pass_result: got vout=%b res=%h pc=%h instr=%h stall=%b req=%b, want 1 00001234 00000040 00b50533 0 0",
               valid_out, result, pc_out, instr_out, stall_m, dmem_req);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL pass_pulse: got vout=%b, want 0", valid_out);
    end
  endtask

  task automatic test_lb_sign();
    int stall_cnt;
    logic [31:0] ins;
    ins = mk_instr(OPC_LOAD, 3'b000);
    @(posedge clk); #1;
    valid_in = 1'b1; instr_in = ins; data_in = 32'h103; pc_in = 32'h80;
    @(negedge clk);
    stall_cnt = int'(stall_m);
    @(posedge clk); #1;
    valid_in = 1'b0;
    for (int w = 0; w < 2; w++) begin
      dmem_ack = (w == 1); dmem_rdata = (w == 1) ? 32'h80FF_FF00 : $urandom;
      @(negedge clk);
      stall_cnt += int'(stall_m);
      n_tests++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be} !== {1'b1, 1'b0, 32'h100, 4'b1000}) begin
        n_fail++;
        $display("FAIL lb_bus: got req=%b we=%b addr=%h be=%b, want 1 0 00000100 1000", dmem_req, dmem_we, dmem_addr, dmem_be);
      end
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    @(negedge clk);
    stall_cnt += int'(stall_m);
    n_tests++;
    if ({valid_out, result, pc_out, instr_out} !== {1'b1, 32'hFFFF_FF80, 32'h80, ins}) begin
      n_fail++;
      $display("FAIL lb_result: got vout=%b res=%h pc=%h instr=%h, want 1 ffffff80 00000080 %h", valid_out, result, pc_out, instr_out, ins);
    end
    n_tests++;
    if (stall_cnt !== 2) begin
      n_fail++; $display("FAIL lb_stall_cycles: got %0d, want 2", stall_cnt);
    end
  endtask

  task automatic test_sh();
    @(posedge clk); #1;
    valid_in = 1'b1; instr_in = mk_instr(OPC_STORE, 3'b001); data_in = 32'h202; store_val = 32'hDEAD_BEEF; pc_in = 32'hC0;
    for (int w = 0; w < 3; w++) begin
      @(posedge clk); #1;
      valid_in = 1'b0; data_in = $urandom; store_val = $urandom;
      dmem_ack = (w == 2);
      @(negedge clk);
      n_tests++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF}) begin
        n_fail++;
        $display("FAIL sh_bus: got req=%b we=%b addr=%h be=%b wdata=%h, want 1 1 00000200 1100 beefbeef",
                 dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
      end
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({valid_out, result, dmem_req} !== {1'b1, 32'h202, 1'b0}) begin
      n_fail++; $display("FAIL sh_done: got vout=%b res=%h req=%b, want 1 00000202 0", valid_out, result, dmem_req);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] i1, i2, d1, d2;
    i1 = mk_instr(OPC_LOAD, 3'b010); i2 = mk_instr(OPC_LOAD, 3'b010);
    d1 = $urandom; d2 = $urandom;
    @(posedge clk); #1;
    valid_in = 1'b1; instr_in = i1; data_in = 32'h300; pc_in = 32'h100;
    @(posedge clk); #1;
    instr_in = i2; data_in = 32'h404; pc_in = 32'h104; dmem_ack = 1'b1; dmem_rdata = d1;
    @(negedge clk);
    n_tests++;
    if ({dmem_req, stall_m, dmem_addr} !== {2'b11, 32'h300}) begin
      n_fail++; $display("FAIL b2b_req1: got req=%b stall=%b addr=%h, want 1 1 00000300", dmem_req, stall_m, dmem_addr);
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({valid_out, result, pc_out, dmem_req, stall_m} !== {1'b1, d1, 32'h100, 2'b00}) begin
      n_fail++;
      $display("FAIL b2b_ret1: got vout=%b res=%h pc=%h req=%b stall=%b, want 1 %h 00000100 0 0", valid_out, result, pc_out, dmem_req, stall_m, d1);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; dmem_ack = 1'b1; dmem_rdata = d2;
    @(negedge clk);
    n_tests++;
    if ({dmem_req, dmem_addr, valid_out} !== {1'b1, 32'h404, 1'b0}) begin
      n_fail++; $display("FAIL b2b_req2: got req=%b addr=%h vout=%b, want 1 00000404 0", dmem_req, dmem_addr, valid_out);
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({valid_out, result, pc_out, instr_out} !== {1'b1, d2, 32'h104, i2}) begin
      n_fail++;
      $display("FAIL b2b_ret2: got vout=%b res=%h pc=%h instr=%h, want 1 %h 00000104 %h", valid_out, result, pc_out, instr_out, d2, i2);
    end
  endtask

  task automatic test_misaligned();
    @(posedge clk); #1;
    valid_in = 1'b1; instr_in = mk_instr(OPC_LOAD, 3'b010); data_in = 32'h101; pc_in = 32'h200;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
`ifdef MEM_MISALIGN_TRAP_EN
    n_tests++;
    if ({dmem_req, stall_m, valid_out, misaligned, result} !== {4'b0011, 32'h101}) begin
      n_fail++;
      $display("FAIL mis_trap: got req=%b stall=%b vout=%b mis=%b res=%h, want 0 0 1 1 00000101", dmem_req, stall_m, valid_out, misaligned, result);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({dmem_req, valid_out, misaligned} !== 3'b000) begin
      n_fail++; $display("FAIL mis_pulse: got req=%b vout=%b mis=%b, want 000", dmem_req, valid_out, misaligned);
    end
`else
    n_tests++;
    if ({dmem_req, dmem_addr, dmem_be, misaligned} !== {1'b1, 32'h100, 4'b1111, 1'b0}) begin
      n_fail++;
      $display("FAIL mis_aligned_req: got req=%b addr=%h be=%b mis=%b, want 1 00000100 1111 0", dmem_req, dmem_addr, dmem_be, misaligned);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({valid_out, result, misaligned} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
      n_fail++; $display("FAIL mis_aligned_ret: got vout=%b res=%h mis=%b, want 1 cafef00d 0", valid_out, result, misaligned);
    end
`endif
  endtask

  task automatic test_reset_busy();
    @(posedge clk); #1;
    valid_in = 1'b1; instr_in = mk_instr(OPC_LOAD, 3'b000); data_in = 32'h55; pc_in = 32'h300;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    n_tests++;
    if (dmem_req !== 1'b1) begin
      n_fail++; $display("FAIL rstbusy_pre: got req=%b, want 1", dmem_req);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = $urandom;
    @(negedge clk);
    n_tests++;
    if ({dmem_req, stall_m, valid_out} !== 3'b000) begin
      n_fail++; $display("FAIL rstbusy_abort: got req=%b stall=%b vout=%b, want 000", dmem_req, stall_m, valid_out);
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({dmem_req, valid_out} !== 2'b00) begin
      n_fail++; $display("FAIL rstbusy_late_ack: got req=%b vout=%b, want 00", dmem_req, valid_out);
    end
  endtask

  task automatic test_random(input int n_ops);
    for (int k = 0; k < n_ops; k++) begin
      int          kind, nwait;
      int unsigned nb;
      bit          ld, st, uns, trap;
      logic [2:0]  f3;
      logic [31:0] ins, a, sv, pc, rd, rtmp, exp_res;
      kind = $urandom_range(0, 2);
      f3   = 3'($urandom_range(0, 7));
      ld   = (kind == 1);
      st   = (kind == 2);
      uns  = ld && (f3 == 3'd4 || f3 == 3'd5);
      if (ld)      ins = mk_instr(OPC_LOAD, f3);
      else if (st) ins = mk_instr(OPC_STORE, f3);
      else         ins = mk_instr(($urandom_range(0, 1) == 1) ? 7'b0110011 : 7'b0010011, f3);
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      sv = $urandom; pc = $urandom; rd = 32'h0;
      nb = m_nbytes(st, f3);
      trap  = TRAP_EN && (ld || st) && ((a % nb) != 0);
      nwait = $urandom_range(0, 3);

      @(posedge clk); #1;
      valid_in = 1'b1; pc_in = pc; instr_in = ins; data_in = a; store_val = sv; dmem_ack = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({stall_m, dmem_req} !== 2'b00) begin
        n_fail++; $display("FAIL rnd_accept[%0d]: got stall=%b req=%b, want 0 0", k, stall_m, dmem_req);
      end
      @(posedge clk); #1;
      if (!(ld || st) || trap) begin
        valid_in = 1'b0; data_in = $urandom;
        @(negedge clk);
        n_tests++;
        if ({valid_out, result, pc_out, instr_out, misaligned, dmem_req} !== {1'b1, a, pc, ins, trap, 1'b0}) begin
          n_fail++;
          $display("FAIL rnd_direct[%0d]: got vout=%b res=%h pc=%h instr=%h mis=%b req=%b, want 1 %h %h %h %b 0",
                   k, valid_out, result, pc_out, instr_out, misaligned, dmem_req, a, pc, ins, trap);
        end
      end else begin
        for (int w = 0; w <= nwait; w++) begin
          valid_in = 1'($urandom); instr_in = $urandom; data_in = $urandom; store_val = $urandom; pc_in = $urandom;
          rtmp = $urandom; dmem_rdata = rtmp; dmem_ack = (w == nwait);
          if (w == nwait) rd = rtmp;
          @(negedge clk);
          n_tests++;
          if ({dmem_req, dmem_we, dmem_addr, dmem_be, stall_m, valid_out} !== {1'b1, st, a[31:2], 2'b00, m_be(a, nb), 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rnd_busy[%0d]: got req=%b we=%b addr=%h be=%b stall=%b vout=%b, want 1 %b %h %b 1 0",
                     k, dmem_req, dmem_we, dmem_addr, dmem_be, stall_m, valid_out, st, {a[31:2], 2'b00}, m_be(a, nb));
          end
          if (st) begin
            n_tests++;
            if (dmem_wdata !== m_wdata(sv, nb)) begin
              n_fail++; $display("FAIL rnd_wdata[%0d]: got %h, want %h", k, dmem_wdata, m_wdata(sv, nb));
            end
          end
          @(posedge clk); #1;
        end
        valid_in = 1'b0; dmem_ack = 1'b0;
        exp_res = st ? a : m_load(rd, a, nb, uns);
        @(negedge clk);
        n_tests++;
        if ({valid_out, result, pc_out, instr_out, misaligned, stall_m, dmem_req} !== {1'b1, exp_res, pc, ins, 3'b000}) begin
          n_fail++;
          $display("FAIL rnd_retire[%0d]: got vout=%b res=%h pc=%h instr=%h mis=%b stall=%b req=%b, want 1 %h %h %h 0 0 0",
                   k, valid_out, result, pc_out, instr_out, misaligned, stall_m, dmem_req, exp_res, pc, ins);
        end
      end
      @(posedge clk); #1;
      valid_in = 1'b0; dmem_ack = 1'($urandom); dmem_rdata = $urandom;
      @(negedge clk);
      n_tests++;
      if ({valid_out, dmem_req, misaligned} !== 3'b000) begin
        n_fail++; $display("FAIL rnd_gap[%0d]: got vout=%b req=%b mis=%b, want 000", k, valid_out, dmem_req, misaligned);
      end
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lb_sign();
    test_sh();
    test_back_to_back();
    test_misaligned();
    test_reset_busy();
    test_random(60);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
